// File: rtl/decode_pkg.sv
// decode_pkg: shared encodings for the decode stage and its condition checker.
// Rev 1.0
`default_nettype none

package decode_pkg;

  typedef enum logic [1:0] {
    CLS_DP  = 2'd0,
    CLS_MEM = 2'd1,
    CLS_BR  = 2'd2,
    CLS_NOP = 2'd3
  } inst_class_t;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [3:0] LINK_REG = 4'hE;

  // Class from inst[27:25]: 00x DP, 01x MEM, 101 BR, 100/11x undefined.
  function automatic inst_class_t classify(input logic [2:0] bits);
    inst_class_t c;
    c = CLS_NOP;
    if (bits[2:1] == 2'b00)      c = CLS_DP;
    else if (bits[2:1] == 2'b01) c = CLS_MEM;
    else if (bits == 3'b101)     c = CLS_BR;
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/decode_stage_cond_check.sv
// cond_check: evaluates an ARM condition field against NZCV flags.
// Rev 1.0
`default_nettype none

module cond_check
  import decode_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       met
);

  logic n, z, c, v;

  assign n = nzcv[FLAG_N];
  assign z = nzcv[FLAG_Z];
  assign c = nzcv[FLAG_C];
  assign v = nzcv[FLAG_V];

  always_comb begin
    met = 1'b0;
    case (cond)
      COND_EQ: met = z;
      COND_NE: met = !z;
      COND_CS: met = c;
      COND_CC: met = !c;
      COND_MI: met = n;
      COND_PL: met = !n;
      COND_VS: met = v;
      COND_VC: met = !v;
      COND_HI: met = c && !z;
      COND_LS: met = !c || z;
      COND_GE: met = (n == v);
      COND_LT: met = (n != v);
      COND_GT: met = !z && (n == v);
      COND_LE: met = z || (n != v);
      COND_AL: met = 1'b1;
      COND_NV: met = 1'b0;
      default: met = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
// decode_stage: decodes one instruction per handshake into a one-entry output
// register toward execute and issues branch redirects back to fetch. Rev 1.0
`default_nettype none

module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int PC_AHEAD = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] inst_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [3:0]      flags_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [1:0]      class_o,
  output logic [3:0]      opcode_o,
  output logic            s_o,
  output logic            imm_sel_o,
  output logic            pre_o,
  output logic            up_o,
  output logic [3:0]      rn_o,
  output logic [3:0]      rd_o,
  output logic [3:0]      rm_o,
  output logic [11:0]     imm12_o,
  output logic            link_o,
  output logic [XLEN-1:0] link_addr_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] branch_target_o
);

  logic            squash_r;
  inst_class_t     cls;
  logic            cond_met;
  logic            accept;
  logic            taken;
  logic            is_bl;
  logic            issue;
  logic [XLEN-1:0] offset;
  logic [XLEN-1:0] target;

  cond_check u_cond (
    .cond (inst_i[31:28]),
    .nzcv (flags_i),
    .met  (cond_met)
  );

  assign cls     = classify(inst_i[27:25]);
  assign ready_o = !valid_o || ready_i;
  assign accept  = valid_i && ready_o;

  // A squashed word is the wrong-path fetch behind a redirect: it never issues
  // and never redirects, even if it is itself a taken branch.
  assign taken = !squash_r && cond_met && (cls == CLS_BR);
  assign is_bl = taken && inst_i[24];
  assign issue = !squash_r && cond_met && ((cls == CLS_DP) || (cls == CLS_MEM) || is_bl);

  assign offset = {{(XLEN-26){inst_i[23]}}, inst_i[23:0], 2'b00};
  assign target = pc_i + XLEN'(PC_AHEAD) + offset;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o         <= 1'b0;
      redirect_o      <= 1'b0;
      squash_r        <= 1'b0;
      class_o         <= 2'd0;
      opcode_o        <= 4'd0;
      s_o             <= 1'b0;
      imm_sel_o       <= 1'b0;
      pre_o           <= 1'b0;
      up_o            <= 1'b0;
      rn_o            <= 4'd0;
      rd_o            <= 4'd0;
      rm_o            <= 4'd0;
      imm12_o         <= 12'd0;
      link_o          <= 1'b0;
      link_addr_o     <= '0;
      branch_target_o <= '0;
    end else begin
      redirect_o <= 1'b0;
      if (accept) begin
        valid_o     <= issue;
        redirect_o  <= taken;
        squash_r    <= taken;
        class_o     <= cls;
        opcode_o    <= inst_i[24:21];
        s_o         <= inst_i[20];
        imm_sel_o   <= inst_i[25];
        pre_o       <= inst_i[24];
        up_o        <= inst_i[23];
        rn_o        <= inst_i[19:16];
        rd_o        <= is_bl ? LINK_REG : inst_i[15:12];
        rm_o        <= inst_i[3:0];
        imm12_o     <= inst_i[11:0];
        link_o      <= is_bl;
        link_addr_o <= pc_i + XLEN'(4);
        if (taken) begin
          branch_target_o <= target;
        end
      end else if (ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed stimulus with queued expectations checked by a monitor.
// Rev 1.0
`default_nettype none

module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst_i;
  logic [31:0] pc_i;
  logic        valid_i;
  logic        ready_o;
  logic [3:0]  flags_i;
  logic        valid_o;
  logic        ready_i;
  logic [1:0]  class_o;
  logic [3:0]  opcode_o;
  logic        s_o;
  logic        imm_sel_o;
  logic        pre_o;
  logic        up_o;
  logic [3:0]  rn_o;
  logic [3:0]  rd_o;
  logic [3:0]  rm_o;
  logic [11:0] imm12_o;
  logic        link_o;
  logic [31:0] link_addr_o;
  logic        redirect_o;
  logic [31:0] branch_target_o;

  decode_stage #(.XLEN(32), .PC_AHEAD(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .inst_i          (inst_i),
    .pc_i            (pc_i),
    .valid_i         (valid_i),
    .ready_o         (ready_o),
    .flags_i         (flags_i),
    .valid_o         (valid_o),
    .ready_i         (ready_i),
    .class_o         (class_o),
    .opcode_o        (opcode_o),
    .s_o             (s_o),
    .imm_sel_o       (imm_sel_o),
    .pre_o           (pre_o),
    .up_o            (up_o),
    .rn_o            (rn_o),
    .rd_o            (rd_o),
    .rm_o            (rm_o),
    .imm12_o         (imm12_o),
    .link_o          (link_o),
    .link_addr_o     (link_addr_o),
    .redirect_o      (redirect_o),
    .branch_target_o (branch_target_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  cls;
    logic [3:0]  opcode;
    logic        s;
    logic        imm_sel;
    logic        pre;
    logic        up;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [3:0]  rm;
    logic [11:0] imm12;
    logic        link;
    logic [31:0] link_addr;
    bit          full;
  } exp_t;

  exp_t        vq[$];
  logic [31:0] rq[$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] cls, input logic [3:0] opc, input logic s,
                              input logic imm, input logic pre, input logic up,
                              input logic [3:0] rn, input logic [3:0] rd,
                              input logic [3:0] rm, input logic [11:0] imm12);
    exp_t e;
    e.cls = cls; e.opcode = opc; e.s = s; e.imm_sel = imm; e.pre = pre; e.up = up;
    e.rn = rn; e.rd = rd; e.rm = rm; e.imm12 = imm12;
    e.link = 1'b0; e.link_addr = 32'h0; e.full = 1'b1;
    return e;
  endfunction

  function automatic exp_t mk_bl(input logic [31:0] la);
    exp_t e;
    e = mk(2'd2, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'hE, 4'h0, 12'h0);
    e.link = 1'b1; e.link_addr = la; e.full = 1'b0;
    return e;
  endfunction

  task automatic check_item(input exp_t e);
    chk("class", {30'd0, class_o}, {30'd0, e.cls});
    chk("rd", {28'd0, rd_o}, {28'd0, e.rd});
    chk("link", {31'd0, link_o}, {31'd0, e.link});
    if (e.link) chk("link_addr", link_addr_o, e.link_addr);
    if (e.full) begin
      chk("opcode", {28'd0, opcode_o}, {28'd0, e.opcode});
      chk("s", {31'd0, s_o}, {31'd0, e.s});
      chk("imm_sel", {31'd0, imm_sel_o}, {31'd0, e.imm_sel});
      chk("rn", {28'd0, rn_o}, {28'd0, e.rn});
      chk("rm", {28'd0, rm_o}, {28'd0, e.rm});
      chk("imm12", {20'd0, imm12_o}, {20'd0, e.imm12});
      if (e.cls == 2'd1) begin
        chk("pre", {31'd0, pre_o}, {31'd0, e.pre});
        chk("up", {31'd0, up_o}, {31'd0, e.up});
      end
    end
  endtask

  // Monitor: compare the head of each queue whenever the DUT presents output.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_o) begin
        if (vq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_valid: got valid_o=1 class=%0d expected no issue at %0t", class_o, $time);
        end else begin
          check_item(vq[0]);
          if (ready_i) void'(vq.pop_front());
        end
      end
      if (redirect_o) begin
        if (rq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_redirect: got target 0x%0h expected no redirect at %0t", branch_target_o, $time);
        end else begin
          chk("branch_target", branch_target_o, rq.pop_front());
        end
      end
    end
  end

  // Present one word and hold it until handshaken; returns at posedge+1.
  task automatic send(input logic [31:0] inst, input logic [31:0] pc, input logic [3:0] flags);
    int n;
    n = 0;
    inst_i = inst; pc_i = pc; flags_i = flags; valid_i = 1'b1;
    forever begin
      @(negedge clk);
      if (ready_o) break;
      n++;
      if (n > 100) begin
        chk("handshake_timeout", 32'd0, 32'd1);
        valid_i = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  localparam logic [31:0] DP_WORD = 32'hE2821005;

  initial begin
    rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    inst_i = '0; pc_i = '0; flags_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_redirect", {31'd0, redirect_o}, 32'd0);
    chk("rst_ready", {31'd0, ready_o}, 32'd1);
    chk("rst_target", branch_target_o, 32'd0);
    chk("rst_rd", {28'd0, rd_o}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Plain decodes
    vq.push_back(mk(2'd0, 4'h4, 1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 4'd1, 4'd5, 12'h005));
    send(DP_WORD, 32'h40, 4'h0);
    vq.push_back(mk(2'd1, 4'hC, 1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 4'd0, 4'd4, 12'h004));
    send(32'hE5910004, 32'h44, 4'h0);
    vq.push_back(mk(2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd2, 4'd3, 12'h003));
    send(32'hE0012003, 32'h48, 4'h0);

    // B, wrong-path word discarded, then normal decode
    rq.push_back(32'h20);
    send(32'hEA000002, 32'h10, 4'h0);
    send(DP_WORD, 32'h14, 4'h0);
    vq.push_back(mk(2'd0, 4'h4, 1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 4'd1, 4'd5, 12'h005));
    send(DP_WORD, 32'h20, 4'h0);

    // BL with negative offset, then discarded word
    rq.push_back(32'h100);
    vq.push_back(mk_bl(32'h104));
    send(32'hEBFFFFFE, 32'h100, 4'h0);
    send(DP_WORD, 32'h104, 4'h0);

    // BEQ not taken, then taken; squashed word is itself a taken branch
    send(32'h0A000001, 32'h200, 4'b0000);
    rq.push_back(32'h20C);
    send(32'h0A000001, 32'h200, 4'b0100);
    send(32'hEA000002, 32'h204, 4'h0);
    vq.push_back(mk(2'd0, 4'h4, 1'b1, 1'b1, 1'b0, 1'b1, 4'd1, 4'd0, 4'hF, 12'hFFF));
    send(32'h12910FFF, 32'h20C, 4'b0000);
    send(32'h12910FFF, 32'h210, 4'b0100);
    send(32'hFA000000, 32'h214, 4'h0);
    send(32'hEC000000, 32'h218, 4'h0);

    // Backpressure: output holds three cycles, queued word not lost
    ready_i = 1'b0;
    vq.push_back(mk(2'd1, 4'hC, 1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 4'd0, 4'd4, 12'h004));
    send(32'hE5910004, 32'h300, 4'h0);
    vq.push_back(mk(2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd2, 4'd3, 12'h003));
    fork
      send(32'hE0012003, 32'h304, 4'h0);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("ready_stall", {31'd0, ready_o}, 32'd0);
        end
        @(posedge clk); #1;
        ready_i = 1'b1;
      end
    join
    @(posedge clk); #1;

    // Redirect while execute stalls pulses once; squash survives to next handshake
    ready_i = 1'b0;
    rq.push_back(32'h408);
    send(32'hEA000000, 32'h400, 4'h0);
    repeat (3) @(posedge clk);
    #1;
    send(DP_WORD, 32'h404, 4'h0);
    ready_i = 1'b1;

    // Asynchronous reset mid-stream with valid_o held
    ready_i = 1'b0;
    vq.push_back(mk(2'd0, 4'h4, 1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 4'd1, 4'd5, 12'h005));
    send(DP_WORD, 32'h500, 4'h0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, valid_o}, 32'd0);
    chk("async_rst_redirect", {31'd0, redirect_o}, 32'd0);
    vq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    ready_i = 1'b1;
    @(posedge clk); #1;
    vq.push_back(mk(2'd1, 4'hC, 1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 4'd0, 4'd4, 12'h004));
    send(32'hE5910004, 32'h600, 4'h0);

    repeat (5) @(posedge clk);
    #1;
    chk("vq_drained", vq.size(), 32'd0);
    chk("rq_drained", rq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
